// File: rtl/const_pkg.sv
// Shared types and constants for the constant encoder and the decode-side
// immediate extender.
package const_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_IMM_W  = 6;
    localparam int DEF_CNT_W  = 8;

    localparam logic CS_SIGN = 1'b1;
    localparam logic CS_ZERO = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        ONE,
        HI,
        LO
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_SIGN,
        CLS_SPLIT
    } cls_t;

    // Extension mode carried by a single-beat immediate of this class.
    function automatic logic cs_of(cls_t c);
        return (c == CLS_SIGN) ? CS_SIGN : CS_ZERO;
    endfunction

endpackage

// File: rtl/const_classify.sv
// Combinational classifier: decides how a constant maps onto immediates
// and slices out the HI and LO immediate fields.
module const_classify
    import const_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMM_W  = DEF_IMM_W
) (
    input  logic [DATA_W-1:0] in_data,
    output cls_t              cls,
    output logic [IMM_W-1:0]  imm_hi,
    output logic [IMM_W-1:0]  imm_lo
);

    localparam int HI_W = DATA_W - IMM_W;

    logic zero_ok;
    logic sign_ok;

    // Zero-extension wins when both forms would reproduce the value.
    always_comb begin
        zero_ok = (in_data[DATA_W-1:IMM_W] == '0);
        sign_ok = &in_data[DATA_W-1:IMM_W-1];
        if (zero_ok) begin
            cls = CLS_ZERO;
        end else if (sign_ok) begin
            cls = CLS_SIGN;
        end else begin
            cls = CLS_SPLIT;
        end
    end

    // HI field is the upper bits zero-extended; LO field is the low bits.
    always_comb begin
        imm_hi             = '0;
        imm_hi[HI_W-1:0]   = in_data[DATA_W-1:IMM_W];
        imm_lo             = in_data[IMM_W-1:0];
    end

endmodule

// File: rtl/const_encoder.sv
// Encodes an 8-bit constant as one or two immediate beats with the
// extension mode the decode-side extender needs to rebuild it.
module const_encoder
    import const_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMM_W  = DEF_IMM_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IMM_W-1:0]  out_imm,
    output logic              out_cs,
    output logic              out_hi,
    output logic              out_last,
    output logic [CNT_W-1:0]  split_cnt
);

    state_t             state_q;
    state_t             state_d;
    cls_t               cls;
    logic [IMM_W-1:0]   imm_hi;
    logic [IMM_W-1:0]   imm_lo;
    logic [IMM_W-1:0]   lo_q;
    logic [IMM_W-1:0]   lo_d;
    logic               valid_d;
    logic [IMM_W-1:0]   imm_d;
    logic               cs_d;
    logic               hi_d;
    logic               last_d;
    logic               take;
    logic               accept;

    const_classify #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_classify (
        .in_data (in_data),
        .cls     (cls),
        .imm_hi  (imm_hi),
        .imm_lo  (imm_lo)
    );

    assign take     = out_valid && out_ready;
    assign in_ready = (state_q == IDLE) || (take && out_last);
    assign accept   = in_valid && in_ready;

    // Next beat selection: a new constant preempts going idle, so
    // single-beat values stream at one per cycle.
    always_comb begin
        state_d = state_q;
        valid_d = out_valid;
        imm_d   = out_imm;
        cs_d    = out_cs;
        hi_d    = out_hi;
        last_d  = out_last;
        lo_d    = lo_q;
        if (accept) begin
            valid_d = 1'b1;
            if (cls == CLS_SPLIT) begin
                state_d = HI;
                imm_d   = imm_hi;
                cs_d    = CS_ZERO;
                hi_d    = 1'b1;
                last_d  = 1'b0;
                lo_d    = imm_lo;
            end else begin
                state_d = ONE;
                imm_d   = imm_lo;
                cs_d    = cs_of(cls);
                hi_d    = 1'b0;
                last_d  = 1'b1;
            end
        end else if (take) begin
            unique case (state_q)
                HI: begin
                    state_d = LO;
                    imm_d   = lo_q;
                    cs_d    = CS_ZERO;
                    hi_d    = 1'b0;
                    last_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    imm_d   = '0;
                    cs_d    = 1'b0;
                    hi_d    = 1'b0;
                    last_d  = 1'b0;
                end
            endcase
        end
    end

    // State, held LO field and registered output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lo_q      <= '0;
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_cs    <= 1'b0;
            out_hi    <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            out_valid <= valid_d;
            out_imm   <= imm_d;
            out_cs    <= cs_d;
            out_hi    <= hi_d;
            out_last  <= last_d;
        end
    end

    // Saturating count of constants that needed a HI/LO pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_cnt <= '0;
        end else if (accept && (cls == CLS_SPLIT) && (split_cnt != '1)) begin
            split_cnt <= split_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_const_encoder.sv
// Directed bench for const_encoder: fixed vectors plus a full sweep that
// rebuilds every constant with the extender rules.
module tb_const_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_imm;
    logic       out_cs;
    logic       out_hi;
    logic       out_last;
    logic [7:0] split_cnt;
    logic [9:0] beat;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign beat = {out_valid, out_imm, out_cs, out_hi, out_last};

    const_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_cs    (out_cs),
        .out_hi    (out_hi),
        .out_last  (out_last),
        .split_cnt (split_cnt)
    );

    task automatic offer(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic take_beat();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({beat, split_cnt} !== 18'h0)
            $display("FAIL reset_outputs got %h exp %h", {beat, split_cnt}, 18'h0);
        else passed++;
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
        else passed++;
        @(negedge clk);
        total++;
        if (beat !== 10'h0)
            $display("FAIL reset_idle got %h exp %h", beat, 10'h0);
        else passed++;
    endtask

    task automatic test_single(input string nm, input logic [7:0] v,
                               input logic [5:0] imm, input logic cs);
        logic [9:0] exp_b;
        exp_b = {1'b1, imm, cs, 1'b0, 1'b1};
        offer(v);
        total++;
        if (beat !== exp_b)
            $display("FAIL %s got %h exp %h", nm, beat, exp_b);
        else passed++;
        take_beat();
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL %s_done got %b exp 0", nm, out_valid);
        else passed++;
    endtask

    task automatic test_zero();
        test_single("zero_05", 8'h05, 6'b000101, 1'b0);
        test_single("zero_3f", 8'h3F, 6'b111111, 1'b0);
    endtask

    task automatic test_sign();
        test_single("sign_f0", 8'hF0, 6'b110000, 1'b1);
        test_single("sign_e0", 8'hE0, 6'b100000, 1'b1);
    endtask

    task automatic test_split();
        logic [7:0] vals [2] = '{8'h40, 8'hDF};
        logic [5:0] his  [2] = '{6'b000001, 6'b000011};
        logic [5:0] los  [2] = '{6'b000000, 6'b011111};
        for (int i = 0; i < 2; i++) begin
            offer(vals[i]);
            total++;
            if (beat !== {1'b1, his[i], 3'b010})
                $display("FAIL split_hi%0d got %h exp %h", i, beat, {1'b1, his[i], 3'b010});
            else passed++;
            take_beat();
            total++;
            if (beat !== {1'b1, los[i], 3'b001})
                $display("FAIL split_lo%0d got %h exp %h", i, beat, {1'b1, los[i], 3'b001});
            else passed++;
            take_beat();
        end
        total++;
        if (split_cnt !== 8'd2)
            $display("FAIL split_cnt got %0d exp 2", split_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3] = '{8'h01, 8'h02, 8'h03};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = vals[i];
            #1;
            total++;
            if (in_ready !== 1'b1)
                $display("FAIL b2b_ready%0d got %b exp 1", i, in_ready);
            else passed++;
            @(negedge clk);
            total++;
            if (beat !== {1'b1, vals[i][5:0], 3'b001})
                $display("FAIL b2b_beat%0d got %h exp %h", i, beat, {1'b1, vals[i][5:0], 3'b001});
            else passed++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL b2b_done got %b exp 0", out_valid);
        else passed++;
    endtask

    task automatic test_stall();
        offer(8'h80);
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({beat, in_ready} !== {1'b1, 6'b000010, 3'b010, 1'b0})
                $display("FAIL stall_hold%0d got %h exp %h", i, {beat, in_ready},
                         {1'b1, 6'b000010, 3'b010, 1'b0});
            else passed++;
            @(negedge clk);
        end
        take_beat();
        total++;
        if (beat !== {1'b1, 6'b000000, 3'b001})
            $display("FAIL stall_lo got %h exp %h", beat, {1'b1, 6'b000000, 3'b001});
        else passed++;
        take_beat();
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL stall_done got %b exp 0", out_valid);
        else passed++;
    endtask

    task automatic test_reset_mid();
        offer(8'hC0);
        total++;
        if (beat !== {1'b1, 6'b000011, 3'b010})
            $display("FAIL rmid_hi got %h exp %h", beat, {1'b1, 6'b000011, 3'b010});
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({beat, split_cnt} !== 18'h0)
            $display("FAIL rmid_async got %h exp %h", {beat, split_cnt}, 18'h0);
        else passed++;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0)
                $display("FAIL rmid_nolo%0d got %b exp 0", i, out_valid);
            else passed++;
        end
        out_ready = 1'b0;
        total++;
        if (split_cnt !== 8'd0)
            $display("FAIL rmid_cnt got %0d exp 0", split_cnt);
        else passed++;
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            offer(8'h40);
            repeat (2) @(negedge clk);
            if (i == 254) begin
                total++;
                if (split_cnt !== 8'd255)
                    $display("FAIL sat_255 got %0d exp 255", split_cnt);
                else passed++;
            end
        end
        out_ready = 1'b0;
        total++;
        if (split_cnt !== 8'd255)
            $display("FAIL sat_hold got %0d exp 255", split_cnt);
        else passed++;
    endtask

    task automatic test_sweep();
        logic [5:0]  b_imm  [4];
        logic        b_cs   [4];
        logic        b_hi   [4];
        logic        b_last [4];
        logic [7:0]  r8;
        logic [11:0] rebuilt;
        logic        flags_ok;
        int          n;
        int          exp_n;
        for (int v = 0; v < 256; v++) begin
            offer(8'(v));
            n = 0;
            while (out_valid && n < 4) begin
                b_imm[n]  = out_imm;
                b_cs[n]   = out_cs;
                b_hi[n]   = out_hi;
                b_last[n] = out_last;
                n++;
                take_beat();
            end
            exp_n = (v < 64 || v >= 224) ? 1 : 2;
            total++;
            if (n !== exp_n || out_valid !== 1'b0)
                $display("FAIL sweep_beats v=%h got %0d exp %0d", v[7:0], n, exp_n);
            else passed++;
            if (n == 1) begin
                r8 = b_cs[0] ? {{2{b_imm[0][5]}}, b_imm[0]} : {2'b00, b_imm[0]};
                rebuilt  = {4'h0, r8};
                flags_ok = b_last[0] && !b_hi[0] && (b_cs[0] == (v >= 224));
            end else if (n == 2) begin
                rebuilt  = {b_imm[0], b_imm[1]};
                flags_ok = b_hi[0] && !b_last[0] && !b_cs[0] &&
                           !b_hi[1] && b_last[1] && !b_cs[1];
            end else begin
                rebuilt  = 12'hFFF;
                flags_ok = 1'b0;
            end
            total++;
            if (rebuilt !== {4'h0, 8'(v)} || !flags_ok)
                $display("FAIL sweep_value v=%h got %h flags %b exp %h flags 1",
                         v[7:0], rebuilt, flags_ok, {4'h0, 8'(v)});
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_sign();
        test_split();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_saturate();
        test_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
